// File: rtl/debounce_bank_pkg.sv
// debounce_bank_pkg: shared repeat-FSM encodings and width helper for the debounce bank
package debounce_bank_pkg;
  typedef enum logic [1:0] {RS_IDLE = 2'd0, RS_DELAY = 2'd1, RS_RPT = 2'd2} rpt_state_e;
  function automatic int clog2w(input int v);
    int w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one channel of synchroniser, stable-time counter and hold-to-repeat FSM
module debounce_chan
  import debounce_bank_pkg::*;
#(
  parameter int DB_TICKS     = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic noisy_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);
  localparam int CW = clog2w(DB_TICKS);
  localparam int RW = clog2w((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic s1_q, s2_q, clean_q, rise_q, fall_q, acc;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    acc   = (s2_q != clean_q) && tick_i && (cnt_q == CW'(DB_TICKS - 1));
    cnt_d = (s2_q == clean_q || acc) ? '0 : cnt_q + CW'(tick_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1_q, s2_q, clean_q, rise_q, fall_q} <= '0;
      cnt_q <= '0;
    end else begin
      s1_q    <= noisy_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_q ^ acc;
      rise_q  <= acc & s2_q;
      fall_q  <= acc & ~s2_q;
    end
  end
  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  if (REPEAT_DELAY == 0) begin : g_norpt
    assign repeat_o = 1'b0;
  end else begin : g_rpt
    rpt_state_e st_q;
    logic [RW-1:0] rcnt_q;
    logic rpt_q;
    // an accepted release wins over a repeat pulse landing on the same tick
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= RS_IDLE;
        rcnt_q <= '0;
        rpt_q  <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (acc && !s2_q) st_q <= RS_IDLE;
        else case (st_q)
          RS_IDLE: if (acc) begin
            st_q   <= RS_DELAY;
            rcnt_q <= '0;
          end
          RS_DELAY: if (tick_i) begin
            if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
              rpt_q  <= 1'b1;
              st_q   <= RS_RPT;
              rcnt_q <= '0;
            end else rcnt_q <= rcnt_q + RW'(1);
          end
          RS_RPT: if (tick_i) begin
            if (rcnt_q == RW'(REPEAT_RATE - 1)) begin
              rpt_q  <= 1'b1;
              rcnt_q <= '0;
            end else rcnt_q <= rcnt_q + RW'(1);
          end
          default: st_q <= RS_IDLE;
        endcase
      end
    end
    assign repeat_o = rpt_q;
  end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: shared tick prescaler driving NCH independent debounce channels
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int NCH          = 5,
  parameter int TICK_DIV     = 100000,
  parameter int DB_TICKS     = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] noisy_i,
  output logic [NCH-1:0] clean_o,
  output logic [NCH-1:0] rise_o,
  output logic [NCH-1:0] fall_o,
  output logic [NCH-1:0] repeat_o
);
  localparam int PW = clog2w(TICK_DIV);
  logic [PW-1:0] pcnt_q;
  logic tick;
  assign tick = pcnt_q == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else pcnt_q <= tick ? '0 : pcnt_q + PW'(1);
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    debounce_chan #(
      .DB_TICKS    (DB_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick),
      .noisy_i (noisy_i[c]),
      .clean_o (clean_o[c]),
      .rise_o  (rise_o[c]),
      .fall_o  (fall_o[c]),
      .repeat_o(repeat_o[c])
    );
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed timing checks plus randomized run against a behavioural model
module tb_debounce_bank;
  localparam int NCH = 2, TD = 4, DB = 3, RD = 5, RR = 2;
  logic clk, rst;
  logic [NCH-1:0] noisy, clean, rise, fall, rpt;
  int errs = 0, checks = 0;

  debounce_bank #(
    .NCH(NCH), .TICK_DIV(TD), .DB_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .noisy_i(noisy), .clean_o(clean),
    .rise_o(rise), .fall_o(fall), .repeat_o(rpt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // model: s is noisy two edges late, tick every TD edges since reset,
  // repeats land on tick indices press+RD+k*RR
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] m_clean, m_rise, m_fall, m_rpt;
  int run[NCH], tp[NCH];
  int cyc, tk;
  always @(posedge clk or posedge rst) begin
    logic [NCH-1:0] s;
    logic tick, re, fe, rp;
    if (rst) begin
      hist = '{'0, '0};
      {m_clean, m_rise, m_fall, m_rpt} = '0;
      cyc = 0;
      tk = 0;
      for (int i = 0; i < NCH; i++) begin run[i] = 0; tp[i] = 0; end
    end else begin
      s = hist[0];
      hist.push_back(noisy);
      void'(hist.pop_front());
      tick = (cyc % TD) == TD - 1;
      cyc++;
      for (int i = 0; i < NCH; i++) begin
        re = 0;
        fe = 0;
        if (s[i] == m_clean[i]) run[i] = 0;
        else if (tick) begin
          run[i]++;
          if (run[i] == DB) begin
            run[i] = 0;
            re = s[i];
            fe = !s[i];
          end
        end
        rp = RD != 0 && tick && m_clean[i] && !fe && (tk - tp[i]) >= RD && ((tk - tp[i] - RD) % RR) == 0;
        if (re) tp[i] = tk;
        if (re || fe) m_clean[i] = s[i];
        m_rise[i] = re;
        m_fall[i] = fe;
        m_rpt[i] = rp;
      end
      if (tick) tk++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkwin(input string nm, input int n, input int lo, input int hi);
    checks++;
    if (n < lo || n > hi) begin
      errs++;
      $display("FAIL %s: got %0d want %0d..%0d at %0t", nm, n, lo, hi, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst) chk("outputs", {clean, rise, fall, rpt}, {m_clean, m_rise, m_fall, m_rpt});

  function automatic logic sig(input int w, input int c);
    return w == 0 ? clean[c] : w == 2 ? rise[c] : w == 3 ? rpt[c] : fall[c];
  endfunction

  task automatic wait_for(input int w, input int c, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(w, c) && n < maxc);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1;
    #1 chk("async_reset", {clean, rise, fall, rpt}, 0);
    @(negedge clk) rst = 0;
  endtask

  initial begin
    int n, k, rate;
    logic seen;
    noisy = 2'b11;
    rst = 0;
    #1 rst = 1;
    #1 chk("reset_no_edge", {clean, rise, fall, rpt}, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    wait_for(0, 0, 30, n);
    chkwin("reset_accept", n, 11, 14);
    chk("reset_rise", {clean, rise}, 4'b1111);
    @(negedge clk) noisy = 2'b10;
    wait_for(4, 0, 30, n);
    chkwin("release_latency", n, 11, 14);
    chk("release_clean", clean, 2'b10);
    @(negedge clk) chk("fall_one_cycle", fall, 2'b00);
    noisy[0] = 1;
    wait_for(2, 0, 30, n);
    chkwin("step_latency", n, 11, 14);
    chk("step_clean", clean, 2'b11);
    @(negedge clk) chk("rise_one_cycle", {rise, fall}, 0);
    noisy[0] = 0;
    wait_for(4, 0, 30, n);
    chkwin("release2_latency", n, 11, 14);
    @(negedge clk) noisy[0] = 1;
    repeat (6) @(negedge clk);
    noisy[0] = 0;
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= clean[0] | rise[0]; end
    chk("glitch6", seen, 0);
    noisy[0] = 1;
    k = 0;
    while (run[0] != DB - 1 && k < 40) begin @(negedge clk); k++; end
    chk("tglitch_arm", k < 40, 1);
    @(negedge clk) noisy[0] = 0;
    @(negedge clk) noisy[0] = 1;
    @(negedge clk) noisy[0] = 0;
    seen = 0;
    repeat (24) begin @(negedge clk); seen |= clean[0] | rise[0]; end
    chk("terminal_glitch", seen, 0);
    noisy[0] = 1;
    wait_for(2, 0, 30, n);
    chkwin("press_latency", n, 11, 14);
    wait_for(3, 0, 40, n);
    chk("first_repeat", n, 20);
    wait_for(3, 0, 20, n);
    chk("repeat_gap1", n, 8);
    wait_for(3, 0, 20, n);
    chk("repeat_gap2", n, 8);
    @(negedge clk) noisy[0] = 0;
    wait_for(4, 0, 30, n);
    seen = 0;
    repeat (30) begin @(negedge clk); seen |= rpt[0]; end
    chk("no_repeat_after_fall", seen, 0);
    noisy[0] = 1;
    wait_for(2, 0, 30, n);
    wait_for(3, 0, 40, n);
    wait_for(3, 0, 20, n);
    mid_reset();
    wait_for(2, 0, 30, n);
    chkwin("post_reset_rise", n, 11, 14);
    chk("post_reset_both", rise, 2'b11);
    wait_for(3, 0, 40, n);
    chk("post_reset_repeat", n, 20);
    rate = 10;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 500 == 0) rate = $urandom_range(1) ? 8 : 60;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(rate - 1) == 0) noisy[c] = ~noisy[c];
      if ($urandom_range(1499) == 0) mid_reset();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
